// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, ALU ops, sequencer states and strobe bundle
package cpu_ctrl_pkg;

  localparam int OPW      = 5;
  localparam int MAXT     = 7;
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = IR_OP_HI - OPW + 1;

  typedef logic [OPW-1:0]               opcode_t;
  typedef logic [4:0]                   aluop_t;
  typedef logic [$clog2(MAXT+1)-1:0]    step_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHL  = 5'b01000;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam aluop_t ALU_ADD = 5'b00011;
  localparam aluop_t ALU_AND = 5'b00101;
  localparam aluop_t ALU_OR  = 5'b00110;

  // T1W is the fetch wait: same strobes as T1 but PCin low so PC loads once.
  typedef enum logic [3:0] {RST, T0, T1, T1W, T2, T3, T4, T5, T6, T7, HLT} state_t;

  typedef struct packed {
    logic   PCout;
    logic   ZMuxOut;
    logic   MDRout;
    logic   Cout;
    logic   BAout;
    logic   ZSelect;
    logic   ZMuxEnable;
    logic   MARin;
    logic   PCin;
    logic   MDRin;
    logic   IRin;
    logic   Yin;
    logic   ALUin;
    logic   Gra;
    logic   Grb;
    logic   Grc;
    logic   Rin;
    logic   Rout;
    logic   IncPC;
    logic   Read;
    logic   Write;
    aluop_t aluControl;
  } strobes_t;

  function automatic step_t stepOf(input state_t s);
    case (s)
      T1, T1W: return step_t'(1);
      T2:      return step_t'(2);
      T3:      return step_t'(3);
      T4:      return step_t'(4);
      T5:      return step_t'(5);
      T6:      return step_t'(6);
      T7:      return step_t'(7);
      default: return step_t'(0);
    endcase
  endfunction

  function automatic logic isRFormat(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic isImm(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic isMemOp(input opcode_t op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // LDI, LD and ST all form Rb + C through the BA path.
  function automatic logic usesBA(input opcode_t op);
    return (op == OP_LDI) || isMemOp(op);
  endfunction

  function automatic aluop_t immAluOp(input opcode_t op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational strobe decode from state and opcode
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t   state,
  input  opcode_t  opcode,
  output strobes_t strobes
);

  always_comb begin
    strobes = '0;
    case (state)
      T0: begin
        strobes.PCout = 1'b1; strobes.MARin = 1'b1;
        strobes.IncPC = 1'b1; strobes.ALUin = 1'b1;
      end
      T1, T1W: begin
        strobes.ZMuxOut = 1'b1; strobes.ZMuxEnable = 1'b1;
        strobes.Read    = 1'b1; strobes.MDRin      = 1'b1;
        strobes.PCin    = (state == T1);
      end
      T2: begin
        strobes.MDRout = 1'b1; strobes.IRin = 1'b1;
      end
      T3: begin
        if (isRFormat(opcode) || isImm(opcode)) begin
          strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.Yin = 1'b1;
        end else if (usesBA(opcode)) begin
          strobes.Grb = 1'b1; strobes.BAout = 1'b1; strobes.Yin = 1'b1;
        end
      end
      T4: begin
        if (isRFormat(opcode)) begin
          strobes.Grc = 1'b1; strobes.Rout = 1'b1; strobes.ALUin = 1'b1;
          strobes.aluControl = opcode;
        end else if (isImm(opcode) || usesBA(opcode)) begin
          strobes.Cout = 1'b1; strobes.ALUin = 1'b1;
          strobes.aluControl = immAluOp(opcode);
        end
      end
      T5: begin
        if (isMemOp(opcode)) begin
          strobes.ZMuxOut = 1'b1; strobes.ZMuxEnable = 1'b1; strobes.MARin = 1'b1;
        end else if (isRFormat(opcode) || isImm(opcode) || opcode == OP_LDI) begin
          strobes.ZMuxOut = 1'b1; strobes.ZMuxEnable = 1'b1;
          strobes.Gra     = 1'b1; strobes.Rin        = 1'b1;
        end
      end
      T6: begin
        if (opcode == OP_LD) begin
          strobes.Read = 1'b1; strobes.MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.MDRin = 1'b1;
        end
      end
      T7: begin
        if (opcode == OP_LD) begin
          strobes.MDRout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer, state and sticky flags
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        ZMuxOut,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        ZSelect,
  output logic        ZMuxEnable,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ALUin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output aluop_t      aluControl,
  output step_t       step,
  output logic        halted,
  output logic        illegal
);

  state_t   state, stateNext;
  opcode_t  opcode;
  strobes_t strobes;
  logic     illegalHit;
  logic     unusedIrBits;

  assign opcode       = ir[IR_OP_HI:IR_OP_LO];
  assign unusedIrBits = ^ir[IR_OP_LO-1:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= RST;
      step    <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= stateNext;
      step  <= stepOf(stateNext);
      if (stateNext == HLT) halted  <= 1'b1;
      if (illegalHit)       illegal <= 1'b1;
    end
  end

  always_comb begin
    stateNext  = state;
    illegalHit = 1'b0;
    case (state)
      RST: stateNext = T0;
      T0:  stateNext = T1;
      T1, T1W: stateNext = mem_ready ? T2 : T1W;
      T2:  stateNext = T3;
      T3: begin
        if (isRFormat(opcode) || isImm(opcode) || usesBA(opcode)) stateNext = T4;
        else if (opcode == OP_HALT)                               stateNext = HLT;
        else begin
          stateNext  = T0;
          illegalHit = (opcode != OP_NOP);
        end
      end
      T4:  stateNext = T5;
      T5:  stateNext = isMemOp(opcode) ? T6 : T0;
      T6:  stateNext = (opcode != OP_LD || mem_ready) ? T7 : T6;
      T7:  stateNext = (opcode != OP_ST || mem_ready) ? T0 : T7;
      HLT: stateNext = HLT;
      default: stateNext = RST;
    endcase
  end

  ctrl_decode uDecode (
    .state   (state),
    .opcode  (opcode),
    .strobes (strobes)
  );

  assign PCout      = strobes.PCout;
  assign ZMuxOut    = strobes.ZMuxOut;
  assign MDRout     = strobes.MDRout;
  assign Cout       = strobes.Cout;
  assign BAout      = strobes.BAout;
  assign ZSelect    = strobes.ZSelect;
  assign ZMuxEnable = strobes.ZMuxEnable;
  assign MARin      = strobes.MARin;
  assign PCin       = strobes.PCin;
  assign MDRin      = strobes.MDRin;
  assign IRin       = strobes.IRin;
  assign Yin        = strobes.Yin;
  assign ALUin      = strobes.ALUin;
  assign Gra        = strobes.Gra;
  assign Grb        = strobes.Grb;
  assign Grc        = strobes.Grc;
  assign Rin        = strobes.Rin;
  assign Rout       = strobes.Rout;
  assign IncPC      = strobes.IncPC;
  assign Read       = strobes.Read;
  assign Write      = strobes.Write;
  assign aluControl = strobes.aluControl;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed vector bench for control_sequencer
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        memReady = 1'b1;
  logic PCout, ZMuxOut, MDRout, Cout, BAout, ZSelect, ZMuxEnable, MARin, PCin;
  logic MDRin, IRin, Yin, ALUin, Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic [4:0] aluControl;
  logic [2:0] step;
  logic halted, illegal;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(memReady),
    .PCout(PCout), .ZMuxOut(ZMuxOut), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .ZSelect(ZSelect), .ZMuxEnable(ZMuxEnable), .MARin(MARin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ALUin(ALUin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write),
    .aluControl(aluControl), .step(step), .halted(halted), .illegal(illegal)
  );

  // Bit order of the observed strobe word, MSB first.
  localparam logic [20:0] M_PCOUT = 21'd1 << 20, M_ZMUXOUT = 21'd1 << 19, M_MDROUT = 21'd1 << 18;
  localparam logic [20:0] M_COUT  = 21'd1 << 17, M_BAOUT   = 21'd1 << 16, M_ZEN    = 21'd1 << 14;
  localparam logic [20:0] M_MARIN = 21'd1 << 13, M_PCIN    = 21'd1 << 12, M_MDRIN  = 21'd1 << 11;
  localparam logic [20:0] M_IRIN  = 21'd1 << 10, M_YIN     = 21'd1 << 9,  M_ALUIN  = 21'd1 << 8;
  localparam logic [20:0] M_GRA   = 21'd1 << 7,  M_GRB     = 21'd1 << 6,  M_GRC    = 21'd1 << 5;
  localparam logic [20:0] M_RIN   = 21'd1 << 4,  M_ROUT    = 21'd1 << 3,  M_INCPC  = 21'd1 << 2;
  localparam logic [20:0] M_READ  = 21'd1 << 1,  M_WRITE   = 21'd1 << 0;

  localparam logic [20:0] S_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ALUIN;
  localparam logic [20:0] S_T1   = M_ZMUXOUT | M_ZEN | M_PCIN | M_READ | M_MDRIN;
  localparam logic [20:0] S_T2   = M_MDROUT | M_IRIN;
  localparam logic [20:0] S_T3R  = M_GRB | M_ROUT | M_YIN;
  localparam logic [20:0] S_T3L  = M_GRB | M_BAOUT | M_YIN;
  localparam logic [20:0] S_T4R  = M_GRC | M_ROUT | M_ALUIN;
  localparam logic [20:0] S_T4I  = M_COUT | M_ALUIN;
  localparam logic [20:0] S_T5R  = M_ZMUXOUT | M_ZEN | M_GRA | M_RIN;
  localparam logic [20:0] S_T5L  = M_ZMUXOUT | M_ZEN | M_MARIN;
  localparam logic [20:0] S_T6LD = M_READ | M_MDRIN;
  localparam logic [20:0] S_T6ST = M_GRA | M_ROUT | M_MDRIN;
  localparam logic [20:0] S_T7LD = M_MDROUT | M_GRA | M_RIN;
  localparam logic [20:0] S_T7ST = M_WRITE;

  localparam logic [31:0] I_ADD  = 32'h18918000, I_LD   = 32'h00800000, I_ST  = 32'h10800000;
  localparam logic [31:0] I_ANDI = 32'h68800000, I_NOP  = 32'hD0000000, I_ILL = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic        clr;
    logic [31:0] instr;
    logic        mr;
    logic [20:0] s;
    logic [4:0]  alu;
    logic [2:0]  st;
    logic        h;
    logic        il;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [20:0] observed();
    return {PCout, ZMuxOut, MDRout, Cout, BAout, ZSelect, ZMuxEnable, MARin, PCin,
            MDRin, IRin, Yin, ALUin, Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};
  endfunction

  task automatic tick(input logic c, input logic [31:0] i, input logic m);
    @(negedge clock);
    clear = c; ir = i; memReady = m;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [20:0] s, input logic [4:0] alu,
                       input logic [2:0] st, input logic h, input logic il);
    logic [31:0] act, exp;
    act = {observed(), aluControl, step, halted, illegal};
    exp = {s, alu, st, h, il};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: strobes/alu/step/halted/illegal got %h/%b/%0d/%b/%b want %h/%b/%0d/%b/%b",
                  tag, act[31:11], act[10:6], act[5:3], act[1], act[0], s, alu, st, h, il);
    total++;
    if ($onehot0(act[31:27])) passed++;
    else $display("FAIL %s busSourceOnehot: got %b want at most one set", tag, act[31:27]);
  endtask

  task automatic cmp(input string tag, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic addV(input logic c, input logic [31:0] i, input logic m, input logic [20:0] s,
                      input logic [4:0] alu, input logic [2:0] st, input logic h, input logic il);
    vecs.push_back('{c, i, m, s, alu, st, h, il});
  endtask

  initial begin
    int readCnt, pcinCnt, irinAt, lastRead;

    addV(1, I_ADD, 1, '0, 0, 0, 0, 0);
    addV(0, I_ADD, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_ADD, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_ADD, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_ADD, 1, S_T3R, 0, 3, 0, 0);
    addV(0, I_ADD, 1, S_T4R, 5'b00011, 4, 0, 0);
    addV(0, I_ADD, 1, S_T5R, 0, 5, 0, 0);
    addV(0, I_ADD, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_LD, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_LD, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_LD, 1, S_T3L, 0, 3, 0, 0);
    addV(0, I_LD, 1, S_T4I, 5'b00011, 4, 0, 0);
    addV(0, I_LD, 1, S_T5L, 0, 5, 0, 0);
    addV(0, I_LD, 1, S_T6LD, 0, 6, 0, 0);
    addV(0, I_LD, 1, S_T7LD, 0, 7, 0, 0);
    addV(0, I_LD, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_ST, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_ST, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_ST, 1, S_T3L, 0, 3, 0, 0);
    addV(0, I_ST, 1, S_T4I, 5'b00011, 4, 0, 0);
    addV(0, I_ST, 1, S_T5L, 0, 5, 0, 0);
    addV(0, I_ST, 1, S_T6ST, 0, 6, 0, 0);
    addV(0, I_ST, 0, S_T7ST, 0, 7, 0, 0);
    addV(0, I_ST, 0, S_T7ST, 0, 7, 0, 0);
    addV(0, I_ST, 0, S_T7ST, 0, 7, 0, 0);
    addV(0, I_ST, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_ANDI, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_ANDI, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_ANDI, 1, S_T3R, 0, 3, 0, 0);
    addV(0, I_ANDI, 1, S_T4I, 5'b00101, 4, 0, 0);
    addV(0, I_ANDI, 1, S_T5R, 0, 5, 0, 0);
    addV(0, I_ANDI, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_NOP, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_NOP, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_NOP, 1, '0, 0, 3, 0, 0);
    addV(0, I_NOP, 1, S_T0, 0, 0, 0, 0);
    addV(0, I_ILL, 1, S_T1, 0, 1, 0, 0);
    addV(0, I_ILL, 1, S_T2, 0, 2, 0, 0);
    addV(0, I_ILL, 1, '0, 0, 3, 0, 0);
    addV(0, I_ILL, 1, S_T0, 0, 0, 0, 1);
    addV(0, I_HALT, 1, S_T1, 0, 1, 0, 1);
    addV(0, I_HALT, 1, S_T2, 0, 2, 0, 1);
    addV(0, I_HALT, 1, '0, 0, 3, 0, 1);
    addV(0, I_HALT, 1, '0, 0, 0, 1, 1);

    foreach (vecs[k]) begin
      tick(vecs[k].clr, vecs[k].instr, vecs[k].mr);
      check($sformatf("vec%0d", k), vecs[k].s, vecs[k].alu, vecs[k].st, vecs[k].h, vecs[k].il);
    end

    for (int k = 0; k < 10; k++) begin
      tick(0, I_HALT, 1);
      check($sformatf("haltHold%0d", k), '0, 0, 0, 1, 1);
    end
    tick(1, I_HALT, 1);
    check("haltClear", '0, 0, 0, 0, 0);
    tick(0, I_NOP, 0);
    check("haltClearT0", S_T0, 0, 0, 0, 0);

    // Fetch with memory stalled: mem_ready low for four wait edges.
    readCnt = 0; pcinCnt = 0; irinAt = -1; lastRead = -1;
    for (int k = 0; k < 16; k++) begin
      tick(0, I_NOP, readCnt >= 5);
      if (Read) begin readCnt++; lastRead = k; end
      if (PCin) pcinCnt++;
      if (IRin) begin irinAt = k; break; end
    end
    cmp("fetchWaitReached", int'(irinAt >= 0), 1);
    cmp("fetchWaitReadCycles", readCnt, 5);
    cmp("fetchWaitPcinPulses", pcinCnt, 1);
    cmp("fetchWaitIrinDelay", irinAt - lastRead, 1);

    // Clear during the LD data wait.
    tick(1, I_LD, 1); check("midRst", '0, 0, 0, 0, 0);
    tick(0, I_LD, 1); check("midT0", S_T0, 0, 0, 0, 0);
    tick(0, I_LD, 1); check("midT1", S_T1, 0, 1, 0, 0);
    tick(0, I_LD, 1); check("midT2", S_T2, 0, 2, 0, 0);
    tick(0, I_LD, 1); check("midT3", S_T3L, 0, 3, 0, 0);
    tick(0, I_LD, 1); check("midT4", S_T4I, 5'b00011, 4, 0, 0);
    tick(0, I_LD, 1); check("midT5", S_T5L, 0, 5, 0, 0);
    tick(0, I_LD, 0); check("midT6", S_T6LD, 0, 6, 0, 0);
    tick(0, I_LD, 0); check("midT6Hold", S_T6LD, 0, 6, 0, 0);
    tick(1, I_LD, 0); check("midClear", '0, 0, 0, 0, 0);
    tick(0, I_LD, 0); check("midClearT0", S_T0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
